// File: rtl/cdc_fifo_src_arbiter.sv
// Source-side front end for a clearable CDC FIFO: round-robin packet arbiter
// with per-packet locking plus a drain/clear/wait flush sequencer with timeout.
module cdc_fifo_src_arbiter #(
   parameter int NumIn          = 4,
   parameter int DataWidth      = 32,
   parameter int MaxClearCycles = 64,
   localparam int GW            = (NumIn > 1) ? $clog2(NumIn) : 1,
   localparam int CW            = $clog2(MaxClearCycles + 1)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NumIn*DataWidth-1:0] in_data_i,
   input  logic [NumIn-1:0]           in_valid_i,
   input  logic [NumIn-1:0]           in_last_i,
   output logic [NumIn-1:0]           in_ready_o,
   output logic [DataWidth-1:0]       fifo_data_o,
   output logic                       fifo_valid_o,
   input  logic                       fifo_ready_i,
   output logic                       fifo_clear_o,
   input  logic                       fifo_clear_pending_i,
   input  logic                       flush_req_i,
   output logic                       flush_busy_o,
   output logic                       flush_done_o,
   output logic                       flush_timeout_o,
   output logic [GW-1:0]              grant_o
);

   typedef enum logic [2:0] {ARB, LOCKED, DRAIN, CLEAR, WAIT} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   rr_q, rr_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            seen_q, seen_d;

   logic            arb_found;
   logic [GW-1:0]   arb_idx;
   logic            grant_ok;
   logic            connected;
   logic [GW-1:0]   sel;
   logic            hs;
   logic            hs_last;

   function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] g);
      return (g == GW'(NumIn - 1)) ? '0 : g + GW'(1);
   endfunction

   // Cyclic search for the first valid requester starting at rr_q.
   always_comb begin
      int tmp;
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int k = 0; k < NumIn; k++) begin
         tmp = int'(rr_q) + k;
         if (tmp >= NumIn) tmp = tmp - NumIn;
         if (!arb_found && in_valid_i[GW'(tmp)]) begin
            arb_found = 1'b1;
            arb_idx   = GW'(tmp);
         end
      end
   end

   assign grant_ok  = arb_found && !fifo_clear_pending_i && !flush_req_i;
   assign connected = ((state_q == ARB) && grant_ok) || (state_q == LOCKED) || (state_q == DRAIN);
   assign sel       = (state_q == ARB) ? arb_idx : grant_q;

   always_comb begin
      fifo_valid_o = connected && in_valid_i[sel];
      in_ready_o   = '0;
      if (connected) in_ready_o[sel] = fifo_ready_i;
      fifo_data_o  = in_data_i[int'(sel)*DataWidth +: DataWidth];
   end

   assign hs      = fifo_valid_o && fifo_ready_i;
   assign hs_last = hs && in_last_i[sel];
   assign grant_o = ((state_q == ARB) && grant_ok) ? arb_idx : grant_q;

   assign flush_busy_o = (state_q == DRAIN) || (state_q == CLEAR) || (state_q == WAIT);

   // Next-state and pulse decode; WAIT qualifies done/timeout against the live pending input.
   always_comb begin
      state_d         = state_q;
      rr_d            = rr_q;
      grant_d         = grant_q;
      cnt_d           = cnt_q;
      seen_d          = seen_q;
      fifo_clear_o    = 1'b0;
      flush_done_o    = 1'b0;
      flush_timeout_o = 1'b0;
      case (state_q)
         ARB: begin
            if (flush_req_i) begin
               state_d = CLEAR;
            end else if (grant_ok) begin
               grant_d = arb_idx;
               if (hs_last)  rr_d    = next_idx(arb_idx);
               else if (hs)  state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (hs_last) begin
               rr_d    = next_idx(grant_q);
               state_d = flush_req_i ? CLEAR : ARB;
            end else if (flush_req_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (hs_last) begin
               rr_d    = next_idx(grant_q);
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            fifo_clear_o = 1'b1;
            cnt_d        = '0;
            seen_d       = 1'b0;
            state_d      = WAIT;
         end
         WAIT: begin
            cnt_d  = cnt_q + CW'(1);
            seen_d = seen_q || fifo_clear_pending_i;
            if (seen_q && !fifo_clear_pending_i) begin
               flush_done_o = 1'b1;
               state_d      = ARB;
            end else if (cnt_q == CW'(MaxClearCycles - 1)) begin
               flush_timeout_o = 1'b1;
               state_d         = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB;
         rr_q    <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         seen_q  <= seen_d;
      end
   end

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// Directed, table-driven bench for cdc_fifo_src_arbiter (NumIn=4, 8-bit data,
// MaxClearCycles=8); each vector is one clock cycle of inputs and expectations.
module tb_cdc_fifo_src_arbiter;

   localparam int NumIn = 4;
   localparam int DW    = 8;
   localparam int MaxC  = 8;

   typedef struct {
      logic [3:0] v;
      logic [3:0] l;
      logic       rdy;
      logic       pend;
      logic       flush;
      logic       rst;
      logic       chk;
      logic [3:0] e_irdy;
      logic       e_fv;
      logic [1:0] e_g;
      logic       e_clr;
      logic       e_busy;
      logic       e_done;
      logic       e_to;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [NumIn*DW-1:0] in_data;
   logic [NumIn-1:0] in_valid, in_last, in_ready;
   logic [DW-1:0]    fifo_data;
   logic             fifo_valid, fifo_ready, fifo_clear, fifo_pend;
   logic             flush_req, flush_busy, flush_done, flush_timeout;
   logic [1:0]       grant;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   cdc_fifo_src_arbiter #(.NumIn(NumIn), .DataWidth(DW), .MaxClearCycles(MaxC)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
      .fifo_data_o(fifo_data), .fifo_valid_o(fifo_valid), .fifo_ready_i(fifo_ready),
      .fifo_clear_o(fifo_clear), .fifo_clear_pending_i(fifo_pend),
      .flush_req_i(flush_req), .flush_busy_o(flush_busy), .flush_done_o(flush_done),
      .flush_timeout_o(flush_timeout), .grant_o(grant)
   );

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                               input logic pend, input logic flush, input logic rs, input logic chk,
                               input logic [3:0] ei, input logic efv, input logic [1:0] eg,
                               input logic eclr, input logic ebusy, input logic edone, input logic eto);
      vec_t r;
      r.v = v; r.l = l; r.rdy = rdy; r.pend = pend; r.flush = flush; r.rst = rs; r.chk = chk;
      r.e_irdy = ei; r.e_fv = efv; r.e_g = eg; r.e_clr = eclr;
      r.e_busy = ebusy; r.e_done = edone; r.e_to = eto;
      return r;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL cycle %0d %s: got %0h expected %0h", cyc, name, act, exp);
      end
   endtask

   task automatic checkOutput(input vec_t x);
      cmp("in_ready", 32'(in_ready), 32'(x.e_irdy));
      cmp("fifo_valid", 32'(fifo_valid), 32'(x.e_fv));
      cmp("grant", 32'(grant), 32'(x.e_g));
      cmp("fifo_clear", 32'(fifo_clear), 32'(x.e_clr));
      cmp("flush_busy", 32'(flush_busy), 32'(x.e_busy));
      cmp("flush_done", 32'(flush_done), 32'(x.e_done));
      cmp("flush_timeout", 32'(flush_timeout), 32'(x.e_to));
      if (x.e_fv) cmp("fifo_data", 32'(fifo_data), 32'(8'hA0 + 8'(x.e_g)));
   endtask

   task automatic applyStimulus(input vec_t x);
      @(negedge clk);
      cyc++;
      in_valid = x.v; in_last = x.l; fifo_ready = x.rdy;
      fifo_pend = x.pend; flush_req = x.flush; rst = x.rst;
      #1;
      if (x.chk) checkOutput(x);
   endtask

   initial begin
      in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      in_valid = '0; in_last = '0; fifo_ready = 1'b0;
      fifo_pend = 1'b0; flush_req = 1'b0; rst = 1'b1;
      repeat (2) @(posedge clk);

      // reset state, then round-robin fairness with single-beat packets
      tbl.push_back(mk(4'b0000,4'b0000,0,0,0,0,1, 4'b0000,0,0,0,0,0,0));
      tbl.push_back(mk(4'b1111,4'b1111,1,0,0,0,1, 4'b0001,1,0,0,0,0,0));
      tbl.push_back(mk(4'b1111,4'b1111,1,0,0,0,1, 4'b0010,1,1,0,0,0,0));
      tbl.push_back(mk(4'b1111,4'b1111,1,0,0,0,1, 4'b0100,1,2,0,0,0,0));
      tbl.push_back(mk(4'b1111,4'b1111,1,0,0,0,1, 4'b1000,1,3,0,0,0,0));
      tbl.push_back(mk(4'b1111,4'b1111,1,0,0,0,1, 4'b0001,1,0,0,0,0,0));
      // req1 three-beat locked packet with a ready stall, then req0 (req2 idle)
      tbl.push_back(mk(4'b0011,4'b0000,1,0,0,0,1, 4'b0010,1,1,0,0,0,0));
      tbl.push_back(mk(4'b0011,4'b0000,0,0,0,0,1, 4'b0000,1,1,0,0,0,0));
      tbl.push_back(mk(4'b0011,4'b0000,1,0,0,0,1, 4'b0010,1,1,0,0,0,0));
      tbl.push_back(mk(4'b0011,4'b0010,1,0,0,0,1, 4'b0010,1,1,0,0,0,0));
      tbl.push_back(mk(4'b0001,4'b0001,1,0,0,0,1, 4'b0001,1,0,0,0,0,0));
      // req3 four-beat packet with flush on beat 2: drain, clear, pending 5 cycles, done
      tbl.push_back(mk(4'b1000,4'b0000,1,0,0,0,1, 4'b1000,1,3,0,0,0,0));
      tbl.push_back(mk(4'b1000,4'b0000,1,0,1,0,1, 4'b1000,1,3,0,0,0,0));
      tbl.push_back(mk(4'b1000,4'b0000,1,0,0,0,1, 4'b1000,1,3,0,1,0,0));
      tbl.push_back(mk(4'b1000,4'b1000,1,0,0,0,1, 4'b1000,1,3,0,1,0,0));
      tbl.push_back(mk(4'b1111,4'b1111,1,0,0,0,1, 4'b0000,0,3,1,1,0,0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(4'b1111,4'b1111,1,1,0,0,1, 4'b0000,0,3,0,1,0,0));
      tbl.push_back(mk(4'b1111,4'b1111,1,0,0,0,1, 4'b0000,0,3,0,1,1,0));
      tbl.push_back(mk(4'b1111,4'b1111,1,0,0,0,1, 4'b0001,1,0,0,0,0,0));
      // remote clear blocks grants, then resumption
      for (int i = 0; i < 10; i++)
         tbl.push_back(mk(4'b1111,4'b1111,1,1,0,0,1, 4'b0000,0,0,0,0,0,0));
      tbl.push_back(mk(4'b0010,4'b0010,1,0,0,0,1, 4'b0010,1,1,0,0,0,0));
      // flush with valid requesters refuses the grant; re-requests during CLEAR/WAIT are ignored
      tbl.push_back(mk(4'b1111,4'b1111,1,0,1,0,1, 4'b0000,0,1,0,0,0,0));
      tbl.push_back(mk(4'b0000,4'b0000,1,0,1,0,1, 4'b0000,0,1,1,1,0,0));
      tbl.push_back(mk(4'b0000,4'b0000,1,0,1,0,1, 4'b0000,0,1,0,1,0,0));
      tbl.push_back(mk(4'b0000,4'b0000,1,1,1,0,1, 4'b0000,0,1,0,1,0,0));
      tbl.push_back(mk(4'b0000,4'b0000,1,0,0,0,1, 4'b0000,0,1,0,1,1,0));
      tbl.push_back(mk(4'b0000,4'b0000,1,0,0,0,1, 4'b0000,0,1,0,0,0,0));

      foreach (tbl[i]) applyStimulus(tbl[i]);

      // timeout: request at t, clear at t+1, timeout pulse at t+9, no done
      applyStimulus(mk(4'b0000,4'b0000,1,0,1,0,1, 4'b0000,0,1,0,0,0,0));
      applyStimulus(mk(4'b0000,4'b0000,1,0,0,0,1, 4'b0000,0,1,1,1,0,0));
      for (int i = 0; i < MaxC - 1; i++)
         applyStimulus(mk(4'b0000,4'b0000,1,0,0,0,1, 4'b0000,0,1,0,1,0,0));
      applyStimulus(mk(4'b0000,4'b0000,1,0,0,0,1, 4'b0000,0,1,0,1,0,1));
      applyStimulus(mk(4'b0000,4'b0000,1,0,0,0,1, 4'b0000,0,1,0,0,0,0));

      // reset in WAIT: outputs cleared, grant and round-robin pointer back to 0
      applyStimulus(mk(4'b0000,4'b0000,1,0,1,0,1, 4'b0000,0,1,0,0,0,0));
      applyStimulus(mk(4'b0000,4'b0000,1,0,0,0,1, 4'b0000,0,1,1,1,0,0));
      applyStimulus(mk(4'b0000,4'b0000,1,1,0,0,1, 4'b0000,0,1,0,1,0,0));
      applyStimulus(mk(4'b0000,4'b0000,1,1,0,1,0, 4'b0000,0,0,0,0,0,0));
      applyStimulus(mk(4'b0000,4'b0000,1,0,0,0,1, 4'b0000,0,0,0,0,0,0));
      applyStimulus(mk(4'b1111,4'b1111,1,0,0,0,1, 4'b0001,1,0,0,0,0,0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
